mem_handshake_ram: RTL and testbench

Byte-addressable 512-byte data memory that answers the datapath's MAR/MDR memory requests with the team's enable/opcode/MFC handshake. It latches each request, inserts a configurable number of wait states, then performs a big-endian byte, halfword or word access. It asserts MFC (memory function complete) and holds it until the initiator releases Enable. It sits on the memory side of the datapath's RAM interface and is the responder for the control unit's fetch, load and store sequences.

---
 rtl/mem_handshake_ram.sv | 138 +++++++++++++
 tb/tb_mem_handshake_ram.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_handshake_ram.sv
// Big-endian 512-byte data RAM answering Enable/OpCode requests with an MFC handshake.
// Define MEM_ALIGN_CHECK_EN to report misaligned halfword/word requests on Err.
module mem_handshake_ram #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 512
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Enable,
  input  logic        OpCode,
  input  logic [1:0]  Size,
  input  logic        SignExt,
  input  logic [8:0]  Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        op;
  logic        sx;
  logic [1:0]  sz;
  logic [8:0]  addr;
  logic [31:0] din;
  logic        err_q;

  logic [7:0]  mem [DEPTH];

  logic [8:0]  a;
  logic [8:0]  a1;
  logic [8:0]  a2;
  logic [8:0]  a3;
  logic        mis;
  logic        wr;
  logic [15:0] half;
  logic [31:0] rdata;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (sz == 2'b01 && addr[0]) ||
               (sz[1] && addr[1:0] != 2'b00);
  assign a   = addr;
`else
  assign mis = 1'b0;
  assign a   = (sz == 2'b00) ? addr :
               (sz == 2'b01) ? {addr[8:1], 1'b0} :
                               {addr[8:2], 2'b00};
`endif

  assign a1 = a + 9'd1;
  assign a2 = a + 9'd2;
  assign a3 = a + 9'd3;

  // Byte at the lowest address is the most significant.
  always_comb begin
    half = {mem[a], mem[a1]};
    unique case (sz)
      2'b00:   rdata = {{24{sx & mem[a][7]}}, mem[a]};
      2'b01:   rdata = {{16{sx & half[15]}}, half};
      default: rdata = {mem[a], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  assign wr = (state == WAIT) && (cnt == 4'd0) &&
              !op && !mis && !Clr;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      MFC     <= 1'b0;
      err_q   <= 1'b0;
      DataOut <= 32'd0;
      op      <= 1'b0;
      sx      <= 1'b0;
      sz      <= 2'b00;
      addr    <= 9'd0;
      din     <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Enable) begin
            op    <= OpCode;
            sx    <= SignExt;
            sz    <= Size;
            addr  <= Address;
            din   <= DataIn;
            cnt   <= 4'(LATENCY);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            MFC   <= 1'b1;
            err_q <= mis;
            if (op && !mis) DataOut <= rdata;
            state <= DONE;
          end
        end
        DONE: begin
          if (!Enable) begin
            MFC   <= 1'b0;
            err_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage has no reset; an aborted write never reaches this port.
  always_ff @(posedge Clk) begin
    if (wr) begin
      unique case (sz)
        2'b00: mem[a] <= din[7:0];
        2'b01: begin
          mem[a]  <= din[15:8];
          mem[a1] <= din[7:0];
        end
        default: begin
          mem[a]  <= din[31:24];
          mem[a1] <= din[23:16];
          mem[a2] <= din[15:8];
          mem[a3] <= din[7:0];
        end
      endcase
    end
  end

  assign Err = err_q;

endmodule

// File: tb/tb_mem_handshake_ram.sv
// Randomized bench for mem_handshake_ram against a byte-array reference model.
// Honours MEM_ALIGN_CHECK_EN when the design is built with it.
module tb_mem_handshake_ram;

  localparam int LAT = 3;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        Enable = 1'b0;
  logic        OpCode = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        SignExt = 1'b0;
  logic [8:0]  Address = 9'd0;
  logic [31:0] DataIn = 32'd0;
  logic [31:0] DataOut;
  logic        MFC;
  logic        Err;

  int checks = 0;
  int errors = 0;

  mem_handshake_ram #(.LATENCY(LAT), .DEPTH(512)) dut (
    .Clk(Clk), .Clr(Clr), .Enable(Enable), .OpCode(OpCode),
    .Size(Size), .SignExt(SignExt), .Address(Address),
    .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .Err(Err)
  );

  always #5 Clk = ~Clk;

  // Reference: memory image, latched request and expected outputs.
  logic [7:0]  mdl [512];
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_k = 0;
  bit          r_op;
  bit          r_sx;
  logic [1:0]  r_sz;
  int          r_addr;
  logic [31:0] r_data;
  logic [31:0] e_dout = 32'd0;
  bit          e_mfc = 0;
  bit          e_err = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_access();
    int n;
    int a;
    logic [63:0] v;
    n = (r_sz == 2'b00) ? 1 : (r_sz == 2'b01) ? 2 : 4;
    a = r_addr;
`ifdef MEM_ALIGN_CHECK_EN
    if (a % n != 0) begin
      e_err = 1;
      return;
    end
`else
    a = a - a % n;
`endif
    if (r_op) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | 64'(mdl[a + i]);
      if (r_sx && v[8*n-1]) v = v | ({64{1'b1}} << (8 * n));
      e_dout = v[31:0];
    end else begin
      for (int i = 0; i < n; i++) mdl[a + i] = r_data[8*(n-1-i) +: 8];
    end
  endtask

  // Per-edge model update, then compare every cycle just after the edge.
  always @(posedge Clk) begin
    if (Clr) begin
      m_busy = 0; m_done = 0;
      e_mfc = 0; e_err = 0; e_dout = 32'd0;
    end else if (m_done) begin
      if (!Enable) begin
        m_done = 0; e_mfc = 0; e_err = 0;
      end
    end else if (m_busy) begin
      m_k++;
      if (m_k == LAT + 1) begin
        model_access();
        m_busy = 0; m_done = 1; e_mfc = 1;
      end
    end else if (Enable) begin
      r_op = OpCode; r_sx = SignExt; r_sz = Size;
      r_addr = int'(Address); r_data = DataIn;
      m_busy = 1; m_k = 0;
    end
    #1;
    cmp("mfc", 32'(MFC), 32'(e_mfc));
    cmp("err", 32'(Err), 32'(e_err));
    cmp("dataout", DataOut, e_dout);
  end

  task automatic req(input bit op, input logic [1:0] sz, input bit sx,
                     input int ad, input logic [31:0] d, input int hold,
                     input bit scr, output int lat,
                     output logic [31:0] dout, output logic err);
    @(negedge Clk);
    Enable = 1'b1; OpCode = op; Size = sz; SignExt = sx;
    Address = 9'(ad); DataIn = d;
    @(negedge Clk);
    if (scr) begin
      OpCode = 1'($urandom); Size = 2'($urandom);
      SignExt = 1'($urandom); Address = 9'($urandom);
      DataIn = $urandom;
    end
    lat = 0;
    while (!MFC && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    checks++;
    if (!MFC) begin
      errors++;
      $display("FAIL mfc_timeout t=%0t got 0 want 1", $time);
    end
    dout = DataOut;
    err = Err;
    repeat (hold) @(negedge Clk);
    Enable = 1'b0;
    @(negedge Clk);
  endtask

  int          lat;
  logic [31:0] dout;
  logic        err;

  initial begin
    for (int i = 0; i < 512; i++) mdl[i] = 8'h00;
    repeat (2) @(negedge Clk);
    cmp("rst_dataout", DataOut, 32'd0);
    cmp("rst_mfc", 32'(MFC), 32'd0);
    cmp("rst_err", 32'(Err), 32'd0);
    Clr = 1'b0;

    for (int a = 0; a < 512; a += 4)
      req(1'b0, 2'b10, 1'b0, a, $urandom, 0, 1'b0, lat, dout, err);

    req(1'b0, 2'b10, 1'b0, 8, 32'hDEADBEEF, 0, 1'b0, lat, dout, err);
    cmp("wr_lat", lat, LAT + 1);
    cmp("wr_err", 32'(err), 32'd0);
    req(1'b1, 2'b10, 1'b0, 8, 32'd0, 0, 1'b0, lat, dout, err);
    cmp("rd_word8", dout, 32'hDEADBEEF);
    req(1'b1, 2'b00, 1'b1, 9, 32'd0, 0, 1'b0, lat, dout, err);
    cmp("rd_byte9_sx", dout, 32'hFFFFFFAD);
    req(1'b1, 2'b00, 1'b0, 8, 32'd0, 0, 1'b0, lat, dout, err);
    cmp("rd_byte8_zx", dout, 32'h000000DE);
    req(1'b1, 2'b01, 1'b0, 10, 32'd0, 0, 1'b0, lat, dout, err);
    cmp("rd_half10", dout, 32'h0000BEEF);
    req(1'b0, 2'b01, 1'b0, 10, 32'hFFFF1234, 0, 1'b0, lat, dout, err);
    req(1'b1, 2'b10, 1'b0, 8, 32'd0, 0, 1'b0, lat, dout, err);
    cmp("rd_after_half", dout, 32'hDEAD1234);

    req(1'b0, 2'b10, 1'b0, 4, 32'hCAFEF00D, 0, 1'b0, lat, dout, err);
    req(1'b1, 2'b10, 1'b0, 6, 32'd0, 0, 1'b0, lat, dout, err);
`ifdef MEM_ALIGN_CHECK_EN
    cmp("mis_err", 32'(err), 32'd1);
    cmp("mis_dout", dout, 32'hDEAD1234);
`else
    cmp("mis_err", 32'(err), 32'd0);
    cmp("mis_dout", dout, 32'hCAFEF00D);
`endif

    @(negedge Clk);
    Enable = 1'b1; OpCode = 1'b0; Size = 2'b10;
    Address = 9'd8; DataIn = 32'h11111111;
    repeat (2) @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0; Enable = 1'b0;
    cmp("clr_mfc", 32'(MFC), 32'd0);
    cmp("clr_dout", DataOut, 32'd0);
    repeat (2) @(negedge Clk);
    req(1'b1, 2'b10, 1'b0, 8, 32'd0, 0, 1'b0, lat, dout, err);
    cmp("clr_no_write", dout, 32'hDEAD1234);

    req(1'b1, 2'b10, 1'b0, 8, 32'd0, 10, 1'b1, lat, dout, err);
    cmp("hold_dout", dout, 32'hDEAD1234);
    req(1'b1, 2'b01, 1'b0, 10, 32'd0, 0, 1'b0, lat, dout, err);
    cmp("rerequest_lat", lat, LAT + 1);
    cmp("rerequest_dout", dout, 32'h00001234);

    for (int t = 0; t < 300; t++)
      req(1'($urandom), 2'($urandom), 1'($urandom),
          int'($urandom_range(511, 0)), $urandom,
          int'($urandom_range(3, 0)), 1'b1, lat, dout, err);

    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
